// File: rtl/sram_arb_if.sv
// Requester bus for sram_arb: per-port request/grant handshake, flattened
// address/data slices, one-cycle response pulses and the init-sweep busy flag.
//   master : requester side (drives requests, observes grants/responses)
//   slave  : arbiter side (sram_arb)
interface sram_arb_if #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LG_DEPTH  = 6
);
  logic [NUM_PORTS-1:0]          io_req_valid;
  logic [NUM_PORTS-1:0]          io_req_ready;
  logic [NUM_PORTS-1:0]          io_req_we;
  logic [NUM_PORTS*LG_DEPTH-1:0] io_req_addr;
  logic [NUM_PORTS*WIDTH-1:0]    io_req_din;
  logic [NUM_PORTS-1:0]          io_resp_valid;
  logic [NUM_PORTS*WIDTH-1:0]    io_resp_data;
  logic                          io_busy;

  modport master (
    output io_req_valid, io_req_we, io_req_addr, io_req_din,
    input  io_req_ready, io_resp_valid, io_resp_data, io_busy
  );

  modport slave (
    input  io_req_valid, io_req_we, io_req_addr, io_req_din,
    output io_req_ready, io_resp_valid, io_resp_data, io_busy
  );
endinterface

// File: rtl/sram_arb.sv
// sram_arb: single-port DEPTH x WIDTH SRAM shared by NUM_PORTS requesters
// through a round-robin arbiter. One access per cycle, read latency 1,
// out-of-range writes dropped and out-of-range reads return 0.
// Optional power-up sweep writing INIT_VAL to every word is enabled by
// defining SRAM_ARB_INIT_EN; without it io_busy is tied low.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - sram_arb_if.slave (requests, grants, responses, busy)
module sram_arb #(
  parameter int unsigned     WIDTH     = 8,
  parameter int unsigned     DEPTH     = 64,
  parameter int unsigned     LG_DEPTH  = 6,
  parameter int unsigned     NUM_PORTS = 2,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic      clk,
  input  logic      rst_n,
  sram_arb_if.slave bus
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]              ptr_q, ptr_d;
  logic [NUM_PORTS-1:0]       resp_valid_q, resp_valid_d;
  logic [NUM_PORTS*WIDTH-1:0] resp_data_q, resp_data_d;

  logic [NUM_PORTS-1:0] grant_c;
  logic                 gnt_any_c;
  logic [PW-1:0]        gnt_idx_c;
  logic [PW-1:0]        scan_c;
  logic                 gnt_we_c;
  logic [LG_DEPTH-1:0]  gnt_addr_c;
  logic [WIDTH-1:0]     gnt_din_c;
  logic                 in_range_c;
  logic [WIDTH-1:0]     rd_word_c;
  logic                 busy_c;

  logic                 mem_we_c;
  logic [AW-1:0]        mem_waddr_c;
  logic [WIDTH-1:0]     mem_wdata_c;

`ifdef SRAM_ARB_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;

  // Sweep one word per cycle; the last word moves the FSM to RUN for good.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_INIT) begin
      if (sweep_q == AW'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end else begin
        sweep_d = sweep_q + AW'(1);
      end
    end
  end

  assign busy_c = (state_q == ST_INIT);
`else
  assign busy_c = 1'b0;
`endif

  // Round-robin pick: first valid port at or above the pointer, with wrap.
  always_comb begin
    grant_c   = '0;
    gnt_any_c = 1'b0;
    gnt_idx_c = '0;
    scan_c    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      scan_c = PW'((32'(ptr_q) + i) % NUM_PORTS);
      if (!gnt_any_c && !busy_c && bus.io_req_valid[scan_c]) begin
        gnt_any_c       = 1'b1;
        gnt_idx_c       = scan_c;
        grant_c[scan_c] = 1'b1;
      end
    end
  end

  // Granted request fields and the addressed word.
  always_comb begin
    gnt_we_c   = bus.io_req_we[gnt_idx_c];
    gnt_addr_c = bus.io_req_addr[gnt_idx_c*LG_DEPTH +: LG_DEPTH];
    gnt_din_c  = bus.io_req_din[gnt_idx_c*WIDTH +: WIDTH];
    in_range_c = (32'(gnt_addr_c) < DEPTH);
    rd_word_c  = in_range_c ? mem[AW'(gnt_addr_c)] : '0;
  end

  // Single write port shared between the sweep and granted writes.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_waddr_c = AW'(gnt_addr_c);
    mem_wdata_c = gnt_din_c;
`ifdef SRAM_ARB_INIT_EN
    if (busy_c) begin
      mem_we_c    = 1'b1;
      mem_waddr_c = sweep_q;
      mem_wdata_c = INIT_VAL;
    end else
`endif
    if (gnt_any_c && gnt_we_c && in_range_c) begin
      mem_we_c = 1'b1;
    end
  end

  // Pointer advance and response capture for the granted port.
  always_comb begin
    ptr_d        = ptr_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    if (gnt_any_c) begin
      ptr_d = (gnt_idx_c == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx_c + PW'(1);
      resp_valid_d[gnt_idx_c] = 1'b1;
      if (!gnt_we_c) begin
        resp_data_d[gnt_idx_c*WIDTH +: WIDTH] = rd_word_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
`ifdef SRAM_ARB_INIT_EN
      state_q      <= ST_INIT;
      sweep_q      <= '0;
`endif
    end else begin
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
`ifdef SRAM_ARB_INIT_EN
      state_q      <= state_d;
      sweep_q      <= sweep_d;
`endif
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  assign bus.io_req_ready  = grant_c;
  assign bus.io_resp_valid = resp_valid_q;
  assign bus.io_resp_data  = resp_data_q;
  assign bus.io_busy       = busy_c;

endmodule

// File: tb/tb_sram_arb.sv
// Self-checking bench for sram_arb: directed steps plus randomized traffic
// compared against a behavioural memory/arbitration model.
module tb_sram_arb;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 64;
  localparam int unsigned LG = 7;
  localparam int unsigned NP = 4;
  localparam logic [W-1:0] IV = 8'hA5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_arb_if #(.NUM_PORTS(NP), .WIDTH(W), .LG_DEPTH(LG)) bus ();

  sram_arb #(
    .WIDTH(W), .DEPTH(D), .LG_DEPTH(LG), .NUM_PORTS(NP), .INIT_VAL(IV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] m_mem    [D];
  bit           m_known  [D];
  int           m_ptr;
  logic [W-1:0] m_data   [NP];
  bit           m_dknown [NP];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.io_req_valid = '0;
  endtask

  task automatic drive(input int p, input bit we, input int addr, input logic [W-1:0] din);
    bus.io_req_valid[p]         = 1'b1;
    bus.io_req_we[p]            = we;
    bus.io_req_addr[p*LG +: LG] = LG'(addr);
    bus.io_req_din[p*W +: W]    = din;
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int p = 0; p < NP; p++) begin
      m_data[p]   = '0;
      m_dknown[p] = 1'b1;
    end
  endtask

  task automatic model_fill_init();
    for (int a = 0; a < D; a++) begin
      m_mem[a]   = IV;
      m_known[a] = 1'b1;
    end
  endtask

  function automatic int arb_pick(input logic [NP-1:0] v);
    for (int k = 0; k < NP; k++) begin
      if (v[(m_ptr + k) % NP]) return (m_ptr + k) % NP;
    end
    return -1;
  endfunction

  // One cycle: check grant before the edge, responses after it.
  task automatic step(input string tag);
    int              g;
    int              ga;
    bit              gwe;
    logic [W-1:0]    gd;
    logic [NP-1:0]   exp_rdy;
    logic [63:0]     exp_rv;
    #1;
    g       = arb_pick(bus.io_req_valid);
    exp_rdy = '0;
    exp_rv  = '0;
    gwe     = 1'b0;
    ga      = 0;
    gd      = '0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      exp_rv[g]  = 1'b1;
      gwe = bus.io_req_we[g];
      ga  = int'(bus.io_req_addr[g*LG +: LG]);
      gd  = bus.io_req_din[g*W +: W];
    end
    check({tag, ".ready"}, 64'(bus.io_req_ready), 64'(exp_rdy));
    check({tag, ".busy"}, 64'(bus.io_busy), 64'(0));
    @(posedge clk);
    if (g >= 0) begin
      if (gwe) begin
        if (ga < D) begin
          m_mem[ga]   = gd;
          m_known[ga] = 1'b1;
        end
      end else begin
        m_data[g]   = (ga < D) ? m_mem[ga] : '0;
        m_dknown[g] = (ga >= D) || m_known[ga];
      end
      m_ptr = (g + 1) % NP;
    end
    #1;
    check({tag, ".rvalid"}, 64'(bus.io_resp_valid), exp_rv);
    for (int p = 0; p < NP; p++) begin
      if (m_dknown[p])
        check($sformatf("%s.rdata%0d", tag, p), 64'(bus.io_resp_data[p*W +: W]), 64'(m_data[p]));
    end
  endtask

  // Count busy cycles from reset release (called at the release negedge).
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    bus.io_req_valid = '1;
    check({tag, ".busy_hi"}, 64'(bus.io_busy), 64'(1));
    while (bus.io_busy === 1'b1 && n < 200) begin
      check({tag, ".ready_lo"}, 64'(bus.io_req_ready), 64'(0));
      @(posedge clk);
      #1;
      n++;
    end
    bus.io_req_valid = '0;
    check({tag, ".busy_len"}, 64'(n), 64'(D));
    model_fill_init();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.io_req_valid = '0;
    bus.io_req_we    = '0;
    bus.io_req_addr  = '0;
    bus.io_req_din   = '0;
    for (int a = 0; a < D; a++) m_known[a] = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst.rvalid", 64'(bus.io_resp_valid), 64'(0));
    check("rst.rdata", 64'(bus.io_resp_data), 64'(0));
    check("rst.ready_idle", 64'(bus.io_req_ready), 64'(0));
    @(negedge clk) rst_n = 1'b1;

`ifdef SRAM_ARB_INIT_EN
    count_busy("init");
`else
    check("noinit.busy", 64'(bus.io_busy), 64'(0));
`endif

    // Last word after the sweep (known only when the sweep ran).
    idle(); drive(0, 0, 63, '0); step("rd63");
`ifdef SRAM_ARB_INIT_EN
    check("rd63.a5", 64'(bus.io_resp_data[0 +: W]), 64'(8'hA5));
`endif

    // Write then read-after-write from the other port.
    idle(); drive(0, 1, 5, 8'h3C); step("wr5");
    idle(); drive(1, 0, 5, '0);    step("rd5");
    check("raw.data1", 64'(bus.io_resp_data[W +: W]), 64'(8'h3C));

    // Out-of-range write is dropped, does not alias, read returns 0.
    idle(); drive(0, 1, 6, 8'h5A);  step("wr6");
    idle(); drive(0, 1, 70, 8'hEE); step("wr70");
    idle(); drive(0, 0, 70, '0);    step("rd70");
    check("oor.data0", 64'(bus.io_resp_data[0 +: W]), 64'(0));
    idle(); drive(0, 0, 6, '0);     step("rd6");
    check("alias.data0", 64'(bus.io_resp_data[0 +: W]), 64'(8'h5A));

    // Two ports always valid: grants alternate.
    idle();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 5, '0);
      drive(1, 0, 6, '0);
      step($sformatf("alt%0d", i));
    end

    // Single valid port keeps winning every cycle.
    idle();
    for (int i = 0; i < 4; i++) begin
      drive(2, 1, 10 + i, 8'($urandom));
      step($sformatf("solo%0d", i));
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      idle();
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          int a;
          a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(64, 127))
                                          : int'($urandom_range(0, 15));
          drive(p, 1'($urandom_range(0, 1)), a, 8'($urandom));
        end
      end
      step("rnd");
    end

    // Async reset while a read response is being presented.
    idle(); drive(1, 0, 5, '0); step("pre_rst");
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst2.rvalid", 64'(bus.io_resp_valid), 64'(0));
    check("rst2.rdata", 64'(bus.io_resp_data), 64'(0));
    idle();
    repeat (2) @(posedge clk);

`ifdef SRAM_ARB_INIT_EN
    // Interrupt the sweep at address 20, then require a full-length sweep.
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midsweep.rvalid", 64'(bus.io_resp_valid), 64'(0));
    check("midsweep.rdata", 64'(bus.io_resp_data), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    count_busy("resweep");
`else
    @(negedge clk) rst_n = 1'b1;
    check("rst2.busy", 64'(bus.io_busy), 64'(0));
`endif

    // Memory survives reset (or is re-swept when the sweep is enabled).
    idle(); drive(0, 0, 6, '0); step("post_rst_rd6");
    idle(); drive(3, 0, 70, '0); step("post_rst_rd70");
    idle();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
